// File: rtl/qd_bus_pkg.sv
// Shared definitions for the serial-address SRAM bus: default widths,
// the cycle-counter width and the master FSM state encoding.
package qd_bus_pkg;

  localparam int QD_ADDR_W = 21;
  localparam int QD_DATA_W = 8;
  // Width of the per-state cycle counter; BIT_CYCLES and STROBE_CYCLES must fit.
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_INCR   = 3'd2,
    ST_STROBE = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

endpackage

// File: rtl/addr_serializer.sv
// Parallel-to-serial address shifter. The address is loaded on the accepting
// edge and presented MSB first on o_si, each bit held for BIT_CYCLES cycles
// while i_en is high. o_last flags the final cycle of the final bit.
module addr_serializer
  import qd_bus_pkg::*;
#(
  parameter int ADDR_W     = QD_ADDR_W,
  parameter int BIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic              o_si,
  output logic              o_last
);

  localparam int BIT_CW = $clog2(ADDR_W + 1);

  logic [ADDR_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_hold;
  logic [BIT_CW-1:0] r_bit;
  logic              w_hold_done;

  assign w_hold_done = (r_hold == CNT_W'(BIT_CYCLES - 1));

  // Load the address, then hold each bit for BIT_CYCLES cycles before shifting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg <= '0;
      r_hold  <= '0;
      r_bit   <= '0;
    end else if (i_load) begin
      r_shreg <= i_addr;
      r_hold  <= '0;
      r_bit   <= '0;
    end else if (i_en) begin
      if (w_hold_done) begin
        r_shreg <= {r_shreg[ADDR_W-2:0], 1'b0};
        r_hold  <= '0;
        r_bit   <= r_bit + BIT_CW'(1);
      end else begin
        r_hold  <= r_hold + CNT_W'(1);
      end
    end
  end

  // The serial line idles low outside the shift window.
  assign o_si   = i_en & r_shreg[ADDR_W-1];
  assign o_last = i_en && w_hold_done && (r_bit == BIT_CW'(ADDR_W - 1));

endmodule

// File: rtl/avr_sram_master.sv
// AVR-side initiator of the CPLD serial-address SRAM protocol. A command is
// taken when cmd_valid and cmd_ready are both high at a clock edge (cmd_ready
// is high only in IDLE); cmd_* are registered then and ignored afterwards.
// The address is either shifted in full or, when it directly follows the
// previously completed address without wrapping, reached by one increment
// pulse. A strobe phase and one settle cycle follow.
module avr_sram_master
  import qd_bus_pkg::*;
#(
  parameter int ADDR_W        = QD_ADDR_W,
  parameter int DATA_W        = QD_DATA_W,
  parameter int BIT_CYCLES    = 2,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              avr_si,
  output logic              avr_sreg_en_n,
  output logic              avr_counter_n,
  output logic              avr_we_n,
  output logic              avr_oe_n,
  output logic [DATA_W-1:0] avr_data_out,
  output logic              avr_data_oe,
  input  logic [DATA_W-1:0] avr_data_in,
  output state_t            dbg_state
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_valid;

  logic              w_accept;
  logic              w_incr;
  logic              w_ser_last;
  logic              w_bit_done;
  logic              w_strobe_done;
  logic              w_drive;
  logic [ADDR_W-1:0] w_seq_addr;

  assign w_accept      = cmd_valid && (r_state == ST_IDLE);
  assign w_seq_addr    = r_last_addr + ADDR_W'(1);
  // Increment only for a strictly sequential address; all-ones to zero wraps
  // inside the CPLD counter, so it must be re-shifted.
  assign w_incr        = r_last_valid && (r_last_addr != '1) && (cmd_addr == w_seq_addr);
  assign w_bit_done    = (r_cnt == CNT_W'(BIT_CYCLES - 1));
  assign w_strobe_done = (r_cnt == CNT_W'(STROBE_CYCLES - 1));

  addr_serializer #(
    .ADDR_W     (ADDR_W),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_ser (
    .i_clk  (avr_clk),
    .i_rst  (avr_reset),
    .i_load (w_accept && !w_incr),
    .i_addr (cmd_addr),
    .i_en   (r_state == ST_SHIFT),
    .o_si   (avr_si),
    .o_last (w_ser_last)
  );

  // Next-state selection; each phase ends on its own cycle budget.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = w_incr ? ST_INCR : ST_SHIFT;
      ST_SHIFT:  if (w_ser_last) w_state_nxt = ST_STROBE;
      ST_INCR:   if (w_bit_done) w_state_nxt = ST_STROBE;
      ST_STROBE: if (w_strobe_done) w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus a cycle counter that restarts on every state change.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Command capture at acceptance; later cmd_* activity is ignored.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= cmd_write;
      r_addr  <= cmd_addr;
      r_wdata <= cmd_wdata;
    end
  end

  // Read data is sampled on the last low cycle of avr_oe_n and held until the next read.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      r_rdata <= '0;
    end else if ((r_state == ST_STROBE) && !r_write && w_strobe_done) begin
      r_rdata <= avr_data_in;
    end
  end

  // Remember the completed address so a sequential follow-up can use INCR.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      r_last_addr  <= '0;
      r_last_valid <= 1'b0;
    end else if (r_state == ST_SETTLE) begin
      r_last_addr  <= r_addr;
      r_last_valid <= 1'b1;
    end
  end

  // Outputs decode directly from the state, so the strobe exclusivity rules
  // follow from the states being mutually exclusive.
  assign w_drive       = r_write && ((r_state == ST_STROBE) || (r_state == ST_SETTLE));
  assign cmd_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign avr_sreg_en_n = (r_state != ST_SHIFT);
  assign avr_counter_n = (r_state != ST_INCR);
  assign avr_we_n      = !((r_state == ST_STROBE) && r_write);
  assign avr_oe_n      = !((r_state == ST_STROBE) && !r_write);
  assign avr_data_oe   = w_drive;
  assign avr_data_out  = w_drive ? r_wdata : '0;
  assign rsp_valid     = (r_state == ST_SETTLE) && !r_write;
  assign rsp_rdata     = r_rdata;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_avr_sram_master.sv
// Bench for avr_sram_master: a bus-level CPLD/SRAM model rebuilds the address
// from avr_si / avr_counter_n and services the strobes, while a command-level
// reference memory predicts read data and the shift-or-increment decision.
module tb_avr_sram_master;

  localparam int ADDR_W        = 21;
  localparam int DATA_W        = 8;
  localparam int BIT_CYCLES    = 2;
  localparam int STROBE_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic avr_clk = 1'b0;
  logic avr_reset = 1'b1;
  always #5 avr_clk = ~avr_clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic              avr_si;
  logic              avr_sreg_en_n;
  logic              avr_counter_n;
  logic              avr_we_n;
  logic              avr_oe_n;
  logic [DATA_W-1:0] avr_data_out;
  logic              avr_data_oe;
  logic [DATA_W-1:0] avr_data_in = '0;
  logic [2:0]        dbg_state;

  avr_sram_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BIT_CYCLES(BIT_CYCLES), .STROBE_CYCLES(STROBE_CYCLES)
  ) dut (
    .avr_clk(avr_clk), .avr_reset(avr_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .avr_si(avr_si), .avr_sreg_en_n(avr_sreg_en_n), .avr_counter_n(avr_counter_n),
    .avr_we_n(avr_we_n), .avr_oe_n(avr_oe_n),
    .avr_data_out(avr_data_out), .avr_data_oe(avr_data_oe),
    .avr_data_in(avr_data_in), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference state ----------------
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] cpld_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] exp_q [$];
  bit                m_last_valid = 1'b0;
  logic [ADDR_W-1:0] m_last_addr = '0;
  logic [DATA_W-1:0] m_last_rdata = '0;

  // CPLD-side observations, cleared per operation by the driver
  logic [ADDR_W-1:0] cpld_addr = '0;
  int sh_cnt = 0, inc_cnt = 0, we_cnt = 0, oe_cnt = 0;
  int op_shift_len = 0, op_incr_len = 0, op_we_len = 0, op_oe_len = 0;
  int rsp_count = 0;
  logic bit_first = 1'b0;
  logic [DATA_W-1:0] we_data = '0;

  // ---------------- CPLD / SRAM bus model and scoreboard ----------------
  always @(negedge avr_clk) begin
    if (avr_reset) begin
      sh_cnt = 0; inc_cnt = 0; we_cnt = 0; oe_cnt = 0;
    end else begin
      n_tests++;
      if ((!avr_oe_n && !avr_we_n) || (!avr_sreg_en_n && !avr_counter_n) || (avr_data_oe && !avr_oe_n)) begin
        n_fail++;
        $display("FAIL invariant: oe_n=%0b we_n=%0b sreg_en_n=%0b counter_n=%0b data_oe=%0b",
                 avr_oe_n, avr_we_n, avr_sreg_en_n, avr_counter_n, avr_data_oe);
      end
      // serial address shift
      if (!avr_sreg_en_n) begin
        if (sh_cnt % BIT_CYCLES == 0) bit_first = avr_si;
        else begin
          n_tests++;
          if (avr_si !== bit_first) begin
            n_fail++;
            $display("FAIL si_hold: si=%0b required %0b at shift cycle %0d", avr_si, bit_first, sh_cnt);
          end
        end
        if (sh_cnt % BIT_CYCLES == BIT_CYCLES - 1) cpld_addr = {cpld_addr[ADDR_W-2:0], avr_si};
        sh_cnt++;
      end else if (sh_cnt != 0) begin
        op_shift_len = sh_cnt; sh_cnt = 0;
      end
      // address increment pulse
      if (!avr_counter_n) inc_cnt++;
      else if (inc_cnt != 0) begin
        op_incr_len = inc_cnt; inc_cnt = 0; cpld_addr = cpld_addr + ADDR_W'(1);
      end
      // write strobe
      if (!avr_we_n) begin
        we_cnt++;
        we_data = avr_data_out;
        n_tests++;
        if (avr_data_oe !== 1'b1) begin
          n_fail++;
          $display("FAIL we_drive: data_oe=%0b required 1", avr_data_oe);
        end
      end else if (we_cnt != 0) begin
        op_we_len = we_cnt; we_cnt = 0; cpld_mem[cpld_addr] = we_data;
      end
      // read strobe: data only becomes valid on the last low cycle (access time)
      if (!avr_oe_n) begin
        oe_cnt++;
        if (oe_cnt >= STROBE_CYCLES)
          avr_data_in = cpld_mem.exists(cpld_addr) ? cpld_mem[cpld_addr] : {DATA_W{1'b1}};
        else
          avr_data_in = DATA_W'($urandom);
      end else begin
        if (oe_cnt != 0) begin op_oe_len = oe_cnt; oe_cnt = 0; end
        avr_data_in = DATA_W'($urandom);
      end
      // response scoreboard
      if (rsp_valid) begin
        rsp_count++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h required no response", rsp_rdata);
        end else begin
          if (rsp_rdata !== exp_q[0]) begin
            n_fail++;
            $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input bit churn);
    bit exp_incr;
    int n, rsp0, exp_lat;
    logic [DATA_W-1:0] v;
    exp_incr = m_last_valid && (m_last_addr != {ADDR_W{1'b1}}) && (addr == m_last_addr + ADDR_W'(1));
    exp_lat  = exp_incr ? (BIT_CYCLES + STROBE_CYCLES + 2) : (ADDR_W * BIT_CYCLES + STROBE_CYCLES + 2);
    if (!wr && !ref_mem.exists(addr)) begin
      v = DATA_W'($urandom); ref_mem[addr] = v; cpld_mem[addr] = v;
    end
    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge avr_clk); #1; n++; end
    n_tests++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_wait: cmd_ready=%0b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(posedge avr_clk); #1;
    op_shift_len = 0; op_incr_len = 0; op_we_len = 0; op_oe_len = 0;
    rsp0 = rsp_count;
    if (wr) ref_mem[addr] = wd;
    else exp_q.push_back(ref_mem[addr]);
    if (!churn) cmd_valid = 1'b0;
    n = 0;
    do begin
      if (churn) begin
        cmd_write = 1'($urandom_range(0, 1)); cmd_addr = ADDR_W'($urandom); cmd_wdata = DATA_W'($urandom);
      end
      @(posedge avr_clk); #1; n++;
    end while (!cmd_ready && n < 100);
    n_tests++;
    if (n + 1 != exp_lat) begin n_fail++; $display("FAIL latency: got %0d required %0d", n + 1, exp_lat); end
    n_tests++;
    if (op_shift_len != (exp_incr ? 0 : ADDR_W * BIT_CYCLES)) begin
      n_fail++; $display("FAIL shift_len: got %0d required %0d", op_shift_len, exp_incr ? 0 : ADDR_W * BIT_CYCLES);
    end
    n_tests++;
    if (op_incr_len != (exp_incr ? BIT_CYCLES : 0)) begin
      n_fail++; $display("FAIL incr_len: got %0d required %0d", op_incr_len, exp_incr ? BIT_CYCLES : 0);
    end
    n_tests++;
    if (cpld_addr !== addr) begin n_fail++; $display("FAIL sram_addr: got %h required %h", cpld_addr, addr); end
    n_tests++;
    if (op_we_len != (wr ? STROBE_CYCLES : 0) || op_oe_len != (wr ? 0 : STROBE_CYCLES)) begin
      n_fail++; $display("FAIL strobe_len: we=%0d oe=%0d required we=%0d oe=%0d", op_we_len, op_oe_len,
                         wr ? STROBE_CYCLES : 0, wr ? 0 : STROBE_CYCLES);
    end
    n_tests++;
    if (rsp_count - rsp0 != (wr ? 0 : 1)) begin
      n_fail++; $display("FAIL rsp_count: got %0d required %0d", rsp_count - rsp0, wr ? 0 : 1);
    end
    if (wr) begin
      n_tests++;
      if (cpld_mem[addr] !== wd) begin n_fail++; $display("FAIL sram_wdata: got %h required %h", cpld_mem[addr], wd); end
      n_tests++;
      if (rsp_rdata !== m_last_rdata) begin n_fail++; $display("FAIL rdata_hold: got %h required %h", rsp_rdata, m_last_rdata); end
    end else begin
      m_last_rdata = ref_mem[addr];
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL exp_q_drain: %0d left required 0", exp_q.size()); exp_q.delete(); end
    m_last_addr = addr; m_last_valid = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    avr_reset = 1'b1;
    repeat (3) @(posedge avr_clk);
    #1;
    n_tests++;
    if ({cmd_ready, busy, rsp_valid, avr_si, avr_sreg_en_n, avr_counter_n, avr_we_n, avr_oe_n, avr_data_oe} !== 9'b100011110) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/busy/rsp/si/sreg/cnt/we/oe/doe=%b required 100011110",
               {cmd_ready, busy, rsp_valid, avr_si, avr_sreg_en_n, avr_counter_n, avr_we_n, avr_oe_n, avr_data_oe});
    end
    n_tests++;
    if (rsp_rdata !== '0 || avr_data_out !== '0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h data_out=%h required 0/0", rsp_rdata, avr_data_out);
    end
    avr_reset = 1'b0;
    m_last_valid = 1'b0; m_last_rdata = '0;
  endtask

  task automatic test_write_shift();
    run_cmd(1'b1, 21'h012345, 8'h5A, 1'b0);
  endtask

  task automatic test_read_incr();
    ref_mem[21'h012346] = 8'hA5; cpld_mem[21'h012346] = 8'hA5;
    run_cmd(1'b0, 21'h012346, 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    run_cmd(1'b1, 21'h1FFFFF, DATA_W'($urandom), 1'b0);
    run_cmd(1'b0, 21'h000000, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int rsp0;
    logic [ADDR_W-1:0] seq_addr;
    seq_addr = m_last_addr + ADDR_W'(1);
    rsp0 = rsp_count;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = m_last_addr + ADDR_W'(1000); cmd_wdata = '0;
    @(posedge avr_clk); #1;
    cmd_valid = 1'b0;
    repeat (19) begin @(posedge avr_clk); #1; end
    avr_reset = 1'b1;
    @(posedge avr_clk); #1;
    n_tests++;
    if ({cmd_ready, busy, rsp_valid, avr_si, avr_sreg_en_n, avr_counter_n, avr_we_n, avr_oe_n, avr_data_oe} !== 9'b100011110) begin
      n_fail++;
      $display("FAIL midreset_ctrl: ready/busy/rsp/si/sreg/cnt/we/oe/doe=%b required 100011110",
               {cmd_ready, busy, rsp_valid, avr_si, avr_sreg_en_n, avr_counter_n, avr_we_n, avr_oe_n, avr_data_oe});
    end
    n_tests++;
    if (rsp_rdata !== '0 || avr_data_out !== '0) begin
      n_fail++; $display("FAIL midreset_data: rdata=%h data_out=%h required 0/0", rsp_rdata, avr_data_out);
    end
    avr_reset = 1'b0;
    m_last_valid = 1'b0; m_last_rdata = '0;
    repeat (5) begin @(posedge avr_clk); #1; end
    n_tests++;
    if (rsp_count != rsp0) begin n_fail++; $display("FAIL midreset_rsp: got %0d pulses required 0", rsp_count - rsp0); end
    run_cmd(1'b0, seq_addr, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 12; i++) begin
      a = ($urandom_range(0, 2) == 0) ? ADDR_W'($urandom) : m_last_addr + ADDR_W'(1);
      run_cmd(1'($urandom_range(0, 1)), a, DATA_W'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom) : m_last_addr + ADDR_W'(1);
      run_cmd(1'($urandom_range(0, 1)), a, DATA_W'($urandom), 1'b1);
    end
    cmd_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_shift();
    test_read_incr();
    test_wrap();
    test_reset_mid();
    test_random();
    test_back_to_back();
    repeat (3) @(posedge avr_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avr_sram_master.md
AVR_SRAM_MASTER -- requirements
Module: avr_sram_master

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning): ADDR_W, 21, SRAM address width.
REQ-002 DATA_W, 8, data bus width.
REQ-003 BIT_CYCLES, 2, avr_clk cycles per shifted address bit (the shift register runs at avr_clk/2).
REQ-004 STROBE_CYCLES, 2, avr_clk cycles that avr_oe_n or avr_we_n is held low.
REQ-005 The block SHALL have these ports (name, direction, width, meaning): avr_clk, in, 1, the single clock.
REQ-006 avr_reset, in, 1, synchronous active-high reset.
REQ-007 cmd_valid, in, 1, request present.
REQ-008 cmd_ready, out, 1, request accepted when high with cmd_valid.
REQ-009 cmd_write, in, 1, 1 = write, 0 = read.
REQ-010 cmd_addr, in, ADDR_W, target address.
REQ-011 cmd_wdata, in, DATA_W, write data.
REQ-012 rsp_valid, out, 1, one-cycle read-data pulse.
REQ-013 rsp_rdata, out, DATA_W, read data.
REQ-014 busy, out, 1, not IDLE.
REQ-015 avr_si, out, 1, serial address bit.
REQ-016 avr_sreg_en_n, out, 1, shift enable, active low.
REQ-017 avr_counter_n, out, 1, address increment, active low.
REQ-018 avr_we_n, out, 1, SRAM write strobe.
REQ-019 avr_oe_n, out, 1, SRAM read strobe.
REQ-020 avr_data_out, out, DATA_W, data driven onto the bus.
REQ-021 avr_data_oe, out, 1, bus drive enable.
REQ-022 avr_data_in, in, DATA_W, bus read-back.

Function
REQ-023 The block SHALL be the AVR-side initiator of the CPLD serial-address SRAM protocol.
REQ-024 The FSM SHALL have the states IDLE, SHIFT, INCR, STROBE and SETTLE.
REQ-025 cmd_ready SHALL be high only in IDLE; a request is accepted on a clock edge where cmd_valid and cmd_ready are both high.
REQ-026 At acceptance, cmd_write, cmd_addr and cmd_wdata SHALL be registered; later changes on cmd_* SHALL have no effect.
REQ-027 At acceptance, if last_valid is set and cmd_addr == last_addr+1 with no wrap, the next state SHALL be INCR; otherwise it SHALL be SHIFT.
REQ-028 SHIFT: avr_sreg_en_n low; avr_si SHALL present address bits MSB first, each held for exactly BIT_CYCLES cycles; duration ADDR_W*BIT_CYCLES cycles (42 at defaults); then STROBE.
REQ-029 INCR: avr_counter_n low for BIT_CYCLES cycles with avr_sreg_en_n high; then STROBE.
REQ-030 STROBE on a write: avr_data_oe high and avr_data_out = wdata, both from STROBE entry through the end of SETTLE; avr_we_n low for STROBE_CYCLES cycles.
REQ-031 STROBE on a read: avr_oe_n low for STROBE_CYCLES cycles; avr_data_in SHALL be captured on the last low cycle.
REQ-032 SETTLE: one cycle with all strobes high, then IDLE.
REQ-033 On a read, rsp_valid SHALL pulse for one cycle in SETTLE, and rsp_rdata SHALL hold the captured value until the next read.
REQ-034 avr_oe_n and avr_we_n SHALL never be low in the same cycle.
REQ-035 avr_sreg_en_n and avr_counter_n SHALL never be low in the same cycle.
REQ-036 avr_data_oe SHALL never be high while avr_oe_n is low.
REQ-037 Latency at defaults from the acceptance edge to cmd_ready high again: 46 cycles for a full shift, 6 cycles for an increment.
REQ-038 On leaving SETTLE, last_addr SHALL be set to the completed address and last_valid SHALL be set.
REQ-039 Wrap case: last_addr = all-ones followed by cmd_addr = 0 SHALL use a full SHIFT, not INCR.

Reset
REQ-040 While avr_reset is high at a clock edge, the block SHALL take state IDLE, cmd_ready 1, busy 0, rsp_valid 0, rsp_rdata 0, avr_si 0, avr_sreg_en_n 1, avr_counter_n 1, avr_we_n 1, avr_oe_n 1, avr_data_oe 0, avr_data_out 0, last_valid 0.
REQ-041 A reset asserted mid-operation SHALL abort the operation with no rsp_valid pulse, and the next request SHALL use a full SHIFT.

Structure
REQ-042 The state encoding and the ADDR_W and DATA_W defaults SHALL live in the shared package qd_bus_pkg.
REQ-043 The parallel-to-serial shifter with its bit-hold counter SHALL be the sub-module addr_serializer.

Verification
REQ-044 Reset then write 0x5A to 0x012345: avr_si over 42 cycles reproduces 0x012345 MSB first at 2 cycles per bit; avr_we_n low 2 cycles with avr_data_out = 0x5A; cmd_ready high again at cycle 46.
REQ-045 Read 0x012346 immediately after REQ-044: INCR with avr_counter_n low 2 cycles and no shift; model returns 0xA5; rsp_valid pulses once with rsp_rdata = 0xA5.
REQ-046 Write to 0x1FFFFF then read 0x000000: the read performs a full 42-cycle SHIFT.
REQ-047 avr_reset asserted at cycle 20 of SHIFT: all outputs at reset values next cycle; no rsp_valid; a following request to last_addr+1 uses SHIFT.
REQ-048 cmd_valid held high for back-to-back random requests with cmd_* changed while busy: cmd_ready is never high outside IDLE, captured values are unaffected, and assertions for REQ-034, REQ-035 and REQ-036 hold every cycle.
